// File: rtl/clock_step_ctrl_pkg.sv
// Shared types and constants for the TD4 clock/step controller.
package td4_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } run_state_t;

  typedef logic [1:0] speed_t;

  localparam int unsigned STEP_CNT_W = 16;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/clock_step_ctrl_if.sv
// Operator buttons, speed/halt controls and CPU-advance outputs of the step controller.
interface clock_step_ctrl_if;
  import td4_pkg::*;

  logic                  btn_run;
  logic                  btn_step;
  speed_t                speed_sel;
  logic                  halt_req;
  logic                  cpu_en;
  logic                  running;
  logic [STEP_CNT_W-1:0] step_cnt;

  modport master (
    output btn_run, btn_step, speed_sel, halt_req,
    input  cpu_en, running, step_cnt
  );

  modport slave (
    input  btn_run, btn_step, speed_sel, halt_req,
    output cpu_en, running, step_cnt
  );

endinterface

// File: rtl/clock_step_ctrl_debouncer.sv
// Synchronises and debounces one raw button; emits a one-cycle pulse per accepted press.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      // Any return to the accepted level restarts the stability window.
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign btn_level = r_level;
  assign btn_press = r_press;

endmodule

// File: rtl/clock_step_ctrl.sv
// Generates the TD4 cpu_en strobe: free-run at a selectable ratio, halt, or single-step.
module clock_step_ctrl
  import td4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned RATIO_0         = 100_000_000,
  parameter int unsigned RATIO_1         = 10_000_000,
  parameter int unsigned RATIO_2         = 1_000_000,
  parameter int unsigned RATIO_3         = 1
) (
  input  logic             clk,
  input  logic             rst,
  clock_step_ctrl_if.slave bus
);

  localparam int unsigned MAX_RATIO = max4(RATIO_0, RATIO_1, RATIO_2, RATIO_3);
  localparam int unsigned DIV_W     = (MAX_RATIO > 1) ? $clog2(MAX_RATIO) : 1;

  run_state_t            r_state;
  run_state_t            w_next;
  logic                  w_run_press;
  logic                  w_step_press;
  logic                  w_run_level;
  logic                  w_step_level;
  logic                  w_unused_levels;
  logic [DIV_W-1:0]      r_div;
  logic [DIV_W-1:0]      w_div_next;
  logic [DIV_W-1:0]      w_last;
  speed_t                r_speed;
  logic                  w_speed_chg;
  logic                  r_cpu_en;
  logic                  w_cpu_en_next;
  logic                  r_running;
  logic [STEP_CNT_W-1:0] r_step_cnt;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (bus.btn_run),
    .btn_level (w_run_level),
    .btn_press (w_run_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (bus.btn_step),
    .btn_level (w_step_level),
    .btn_press (w_step_press)
  );

  assign w_unused_levels = w_run_level ^ w_step_level;

  always_comb begin
    w_last = DIV_W'(RATIO_0 - 1);
    case (bus.speed_sel)
      2'd0:    w_last = DIV_W'(RATIO_0 - 1);
      2'd1:    w_last = DIV_W'(RATIO_1 - 1);
      2'd2:    w_last = DIV_W'(RATIO_2 - 1);
      default: w_last = DIV_W'(RATIO_3 - 1);
    endcase
  end

  always_comb begin
    w_next = r_state;
    if (bus.halt_req) begin
      w_next = HALT;
    end else begin
      case (r_state)
        HALT: begin
          if (w_run_press)       w_next = RUN;
          else if (w_step_press) w_next = STEP;
        end
        RUN:     if (w_run_press) w_next = HALT;
        STEP:    w_next = HALT;
        default: w_next = HALT;
      endcase
    end
  end

  // Divider only advances while staying in RUN at an unchanged speed; otherwise it restarts at 0.
  always_comb begin
    w_speed_chg   = (bus.speed_sel != r_speed);
    w_div_next    = '0;
    w_cpu_en_next = 1'b0;
    if (w_next == STEP) begin
      w_cpu_en_next = 1'b1;
    end else if ((r_state == RUN) && (w_next == RUN) && !w_speed_chg) begin
      if (r_div == w_last) w_cpu_en_next = 1'b1;
      else                 w_div_next    = r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HALT;
      r_div      <= '0;
      r_speed    <= '0;
      r_cpu_en   <= 1'b0;
      r_running  <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_div      <= w_div_next;
      r_speed    <= bus.speed_sel;
      r_cpu_en   <= w_cpu_en_next;
      r_running  <= (w_next == RUN);
      r_step_cnt <= r_step_cnt + STEP_CNT_W'(w_cpu_en_next);
    end
  end

  assign bus.cpu_en   = r_cpu_en;
  assign bus.running  = r_running;
  assign bus.step_cnt = r_step_cnt;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Directed self-checking bench for clock_step_ctrl (DEBOUNCE_CYCLES=4, ratios 8/4/2/1).
module tb_clock_step_ctrl;

  logic clk;
  logic rst;
  int unsigned n_chk;
  int unsigned n_err;
  int unsigned n_pulse;
  int unsigned p0;
  logic [63:0] m;

  clock_step_ctrl_if u_if ();

  clock_step_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .RATIO_0         (8),
    .RATIO_1         (4),
    .RATIO_2         (2),
    .RATIO_3         (1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n edges; outputs are sampled 1 time unit after each edge.
  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (u_if.cpu_en === 1'b1) n_pulse++;
    end
  endtask

  task automatic run_pattern(input int unsigned n, output logic [63:0] pat);
    pat = '0;
    for (int unsigned k = 1; k <= n; k++) begin
      tick(1);
      pat[k] = u_if.cpu_en;
    end
  endtask

  // Hold a button for 8 edges: press pulse lands after edge 7, state changes at edge 8.
  task automatic press(input bit run_btn);
    if (run_btn) u_if.btn_run = 1'b1;
    else         u_if.btn_step = 1'b1;
    tick(8);
    u_if.btn_run  = 1'b0;
    u_if.btn_step = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; n_pulse = 0;
    rst = 1'b1;
    u_if.btn_run = 1'b0; u_if.btn_step = 1'b0;
    u_if.speed_sel = 2'd0; u_if.halt_req = 1'b0;

    // 1: reset values, then a held step button gives one pulse at edge 8
    do_reset();
    check("rst_cpu_en", u_if.cpu_en, 0);
    check("rst_running", u_if.running, 0);
    check("rst_step_cnt", u_if.step_cnt, 0);
    u_if.btn_step = 1'b1;
    run_pattern(10, m);
    check("t1_pulse_pos", m, 64'h100);
    u_if.btn_step = 1'b0;
    run_pattern(12, m);
    check("t1_release_quiet", m, 0);
    check("t1_step_cnt", u_if.step_cnt, 1);
    check("t1_running", u_if.running, 0);

    // 2: two-cycle glitch is rejected
    do_reset();
    p0 = n_pulse;
    u_if.btn_step = 1'b1;
    tick(2);
    u_if.btn_step = 1'b0;
    tick(15);
    check("t2_pulses", n_pulse - p0, 0);
    check("t2_step_cnt", u_if.step_cnt, 0);

    // 3: free run at ratio 8, then stop with terminal count coinciding with exit
    do_reset();
    u_if.speed_sel = 2'd0;
    press(1'b1);
    check("t3_running", u_if.running, 1);
    check("t3_entry_no_pulse", u_if.cpu_en, 0);
    run_pattern(40, m);
    check("t3_pulse_train", m, 64'h0000_0101_0101_0100);
    check("t3_step_cnt", u_if.step_cnt, 5);
    p0 = n_pulse;
    press(1'b1);
    check("t3_exit_no_pulse", u_if.cpu_en, 0);
    check("t3_halted", u_if.running, 0);
    tick(20);
    check("t3_halt_quiet", n_pulse - p0, 0);
    check("t3_step_cnt_hold", u_if.step_cnt, 5);

    // 4: speed change restarts the divider; ratio 1 runs continuously
    do_reset();
    u_if.speed_sel = 2'd1;
    press(1'b1);
    run_pattern(6, m);
    check("t4_ratio4", m, 64'h10);
    u_if.speed_sel = 2'd3;
    run_pattern(10, m);
    check("t4_ratio1", m, 64'h7FC);
    u_if.speed_sel = 2'd1;
    run_pattern(13, m);
    check("t4_back_ratio4", m, 64'h2220);
    check("t4_step_cnt", u_if.step_cnt, 13);

    // 5: halt_req blocks the terminal pulse and masks presses
    do_reset();
    u_if.speed_sel = 2'd0;
    press(1'b1);
    check("t5_running", u_if.running, 1);
    tick(7);
    u_if.halt_req = 1'b1;
    p0 = n_pulse;
    tick(1);
    check("t5_no_term_pulse", u_if.cpu_en, 0);
    check("t5_halted", u_if.running, 0);
    tick(10);
    press(1'b1);
    tick(10);
    press(1'b0);
    tick(10);
    check("t5_masked_running", u_if.running, 0);
    check("t5_masked_pulses", n_pulse - p0, 0);
    check("t5_masked_cnt", u_if.step_cnt, 0);
    u_if.halt_req = 1'b0;
    tick(2);
    press(1'b0);
    check("t5_step_pulse", u_if.cpu_en, 1);
    check("t5_step_cnt", u_if.step_cnt, 1);
    tick(1);
    check("t5_step_single", u_if.cpu_en, 0);

    // 6: drive step_cnt to 0xFFFE at full speed, wrap via steps, reset inside STEP
    do_reset();
    u_if.speed_sel = 2'd3;
    press(1'b1);
    tick(65534);
    u_if.halt_req = 1'b1;
    tick(1);
    check("t6_cnt_fffe", u_if.step_cnt, 16'hFFFE);
    check("t6_halt_no_pulse", u_if.cpu_en, 0);
    u_if.halt_req = 1'b0;
    tick(2);
    press(1'b0);
    check("t6_cnt_ffff", u_if.step_cnt, 16'hFFFF);
    tick(10);
    press(1'b0);
    check("t6_cnt_wrap", u_if.step_cnt, 16'h0000);
    tick(10);
    press(1'b0);
    check("t6_in_step", u_if.cpu_en, 1);
    rst = 1'b1;
    tick(1);
    check("t6_rst_cpu_en", u_if.cpu_en, 0);
    check("t6_rst_running", u_if.running, 0);
    check("t6_rst_cnt", u_if.step_cnt, 0);
    rst = 1'b0;
    tick(3);
    check("t6_post_rst_quiet", u_if.cpu_en, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
